// File: rtl/ifc_or_driver.sv
// Initiator for the ifc_or method interface: issues operand pairs on a/b, collects y,
// and scores each result against a|b with saturating pass/fail counts.
module ifc_or_driver #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       a_data,
  output logic       a_en,
  input  logic       a_rdy,
  output logic       b_data,
  output logic       b_en,
  input  logic       b_rdy,
  input  logic       y_data,
  output logic       y_en,
  input  logic       y_rdy,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUT  = 2'd1;
  localparam logic [1:0] S_GET  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [7:0] LAST_IDX  = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] idx;
  logic [7:0] idx_next;
  logic [7:0] wait_cnt;
  logic       a_sent;
  logic       b_sent;
  logic       y_match;

  // Enables are masked during reset so nothing fires in the reset cycle itself.
  always_comb begin
    a_en     = ~RST && (state == S_PUT) && ~a_sent && a_rdy;
    b_en     = ~RST && (state == S_PUT) && ~b_sent && b_rdy;
    y_en     = ~RST && (state == S_GET) && y_rdy;
    busy     = (state == S_PUT) || (state == S_GET);
    idx_next = idx + 8'd1;
    y_match  = (y_data == (a_data | b_data));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      a_sent     <= 1'b0;
      b_sent     <= 1'b0;
      a_data     <= 1'b0;
      b_data     <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pass_count <= '0;
            fail_count <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            a_sent     <= 1'b0;
            b_sent     <= 1'b0;
            a_data     <= 1'b0;
            b_data     <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            state      <= S_PUT;
          end
        end
        S_PUT: begin
          if (a_en) a_sent <= 1'b1;
          if (b_en) b_sent <= 1'b1;
          if ((a_sent || a_en) && (b_sent || b_en)) state <= S_GET;
          if (a_en || b_en) begin
            wait_cnt <= '0;
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            timeout  <= 1'b1;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_GET: begin
          if (y_en) begin
            if (y_match) begin
              if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
            end else begin
              if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            end
            a_sent   <= 1'b0;
            b_sent   <= 1'b0;
            wait_cnt <= '0;
            idx      <= idx_next;
            // Operands for the next vector are loaded here so they are stable on PUT entry.
            a_data   <= idx_next[1];
            b_data   <= idx_next[0];
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_PUT;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            timeout  <= 1'b1;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifc_or_driver.sv
// Directed/randomized bench for ifc_or_driver against a behavioural ifc_or responder.
module tb_ifc_or_driver;

  logic       CLK = 1'b0;
  logic       RST, start, start2;
  logic       a_data, a_en, a_rdy, b_data, b_en, b_rdy, y_data, y_en, y_rdy;
  logic       busy, done, timeout;
  logic [7:0] pass_count, fail_count;
  logic       a_data2, a_en2, a_rdy2, b_data2, b_en2, b_rdy2, y_data2, y_en2, y_rdy2;
  logic       busy2, done2, timeout2;
  logic [7:0] pass_count2, fail_count2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ifc_or_driver #(.NUM_VECTORS(4), .TIMEOUT(16)) u_dut (
    .CLK(CLK), .RST(RST), .start(start),
    .a_data(a_data), .a_en(a_en), .a_rdy(a_rdy),
    .b_data(b_data), .b_en(b_en), .b_rdy(b_rdy),
    .y_data(y_data), .y_en(y_en), .y_rdy(y_rdy),
    .busy(busy), .done(done), .timeout(timeout),
    .pass_count(pass_count), .fail_count(fail_count)
  );

  ifc_or_driver #(.NUM_VECTORS(255), .TIMEOUT(16)) u_big (
    .CLK(CLK), .RST(RST), .start(start2),
    .a_data(a_data2), .a_en(a_en2), .a_rdy(a_rdy2),
    .b_data(b_data2), .b_en(b_en2), .b_rdy(b_rdy2),
    .y_data(y_data2), .y_en(y_en2), .y_rdy(y_rdy2),
    .busy(busy2), .done(done2), .timeout(timeout2),
    .pass_count(pass_count2), .fail_count(fail_count2)
  );

  // Always-ready ideal responder for the long run: y is just a|b of the held operands.
  always_comb y_data2 = a_data2 | b_data2;

  // Behavioural ifc_or for the main instance, with configurable stalls and a faulty mode.
  logic mode_and = 1'b0, rand_rdy = 1'b0, stall_b3 = 1'b0, y_stuck = 1'b0;
  logic have_a, have_b, a_val, b_val;
  int   b_wait, viol;
  logic a_log[$];
  logic b_log[$];
  logic y_log[$];

  always @(posedge CLK) begin
    if (RST) begin
      have_a <= 1'b0;
      have_b <= 1'b0;
      b_wait <= 0;
    end else begin
      if ((a_en && !a_rdy) || (b_en && !b_rdy) || (y_en && !y_rdy)) viol <= viol + 1;
      if (a_en && a_rdy) begin have_a <= 1'b1; a_val <= a_data; a_log.push_back(a_data); end
      if (b_en && b_rdy) begin
        have_b <= 1'b1; b_val <= b_data; b_log.push_back(b_data); b_wait <= 0;
      end else if (!have_b && busy) begin
        b_wait <= b_wait + 1;
      end else if (!busy) begin
        b_wait <= 0;
      end
      if (y_en && y_rdy) begin
        have_a <= 1'b0; have_b <= 1'b0; b_wait <= 0; y_log.push_back(y_data);
      end
    end
  end

  always @(negedge CLK) begin
    a_rdy  = !have_a && (!rand_rdy || ($urandom_range(3) != 0));
    b_rdy  = !have_b && (stall_b3 ? (b_wait >= 3) : (!rand_rdy || ($urandom_range(3) != 0)));
    y_rdy  = have_a && have_b && !y_stuck && (!rand_rdy || ($urandom_range(3) != 0));
    y_data = mode_and ? (a_val & b_val) : (a_val | b_val);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int limit, output int cyc);
    a_log.delete(); b_log.delete(); y_log.delete();
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;
    cyc = 0;
    while (!done && cyc < limit) begin
      @(posedge CLK); @(negedge CLK); cyc++;
    end
  endtask

  // Reference: score every vector k by the rules alone, and check the issued operand sequence.
  task automatic check_run(input string tag, input logic use_and, input int n);
    int exp_pass, seq_err;
    logic [7:0] kv;
    exp_pass = 0;
    seq_err  = 0;
    for (int k = 0; k < n; k++) begin
      kv = 8'(k);
      if ((use_and ? (kv[1] & kv[0]) : (kv[1] | kv[0])) == (kv[1] | kv[0])) exp_pass++;
      if (k < a_log.size() && a_log[k] !== kv[1]) seq_err++;
      if (k < b_log.size() && b_log[k] !== kv[0]) seq_err++;
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pass"}, int'(pass_count), exp_pass);
    check({tag, "_fail"}, int'(fail_count), n - exp_pass);
    check({tag, "_a_fires"}, a_log.size(), n);
    check({tag, "_b_fires"}, b_log.size(), n);
    check({tag, "_operands"}, seq_err, 0);
    check({tag, "_en_vs_rdy"}, viol, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a_en"}, int'(a_en), 0);
    check({tag, "_b_en"}, int'(b_en), 0);
    check({tag, "_y_en"}, int'(y_en), 0);
    check({tag, "_a_data"}, int'(a_data), 0);
    check({tag, "_b_data"}, int'(b_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_pass"}, int'(pass_count), 0);
    check({tag, "_fail"}, int'(fail_count), 0);
  endtask

  initial begin
    int cyc, n;
    RST = 1'b1; start = 1'b0; start2 = 1'b0; viol = 0;
    a_rdy2 = 1'b1; b_rdy2 = 1'b1; y_rdy2 = 1'b1;
    do_reset();
    #1;
    check_reset_values("reset");

    // Full speed against a correct responder: 2 cycles per vector.
    run(100, cyc);
    check("full_cycles", cyc, 8);
    check_run("full", 1'b0, 4);
    repeat (3) @(negedge CLK);
    check("done_holds", int'(done), 1);
    check("pass_holds", int'(pass_count), 4);

    // Responder computes a&b: 00 and 11 agree with a|b.
    mode_and = 1'b1;
    run(100, cyc);
    check_run("and_model", 1'b1, 4);
    mode_and = 1'b0;

    // b held off 3 cycles per vector: 4 PUT cycles + 1 GET cycle each.
    stall_b3 = 1'b1;
    run(200, cyc);
    check("stall_b_cycles", cyc, 20);
    check_run("stall_b", 1'b0, 4);
    stall_b3 = 1'b0;

    // y never ready: one PUT cycle then 16 idle GET cycles.
    y_stuck = 1'b1;
    run(100, cyc);
    check("tmo_cycles", cyc, 17);
    check("tmo_timeout", int'(timeout), 1);
    check("tmo_done", int'(done), 1);
    check("tmo_busy", int'(busy), 0);
    check("tmo_pass", int'(pass_count), 0);
    check("tmo_fail", int'(fail_count), 0);
    @(negedge CLK); #1;
    check("tmo_no_y_en", int'(y_en), 0);
    y_stuck = 1'b0;
    do_reset();

    // Reset during GET of vector 2, then a clean rerun.
    a_log.delete(); b_log.delete(); y_log.delete();
    @(negedge CLK); start = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start = 1'b0;
    n = 0;
    #1;
    while (!(y_en && y_log.size() == 2) && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    check("mid_reached_get2", int'(y_en && y_log.size() == 2), 1);
    check("mid_a_data", int'(a_data), 1);
    check("mid_b_data", int'(b_data), 0);
    RST = 1'b1; #1;
    check("mid_rst_cycle_y_en", int'(y_en), 0);
    @(posedge CLK); @(negedge CLK); RST = 1'b0; #1;
    check_reset_values("mid_reset");
    run(100, cyc);
    check("rerun_cycles", cyc, 8);
    check_run("rerun", 1'b0, 4);

    // Random stall patterns with a random responder model.
    rand_rdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      mode_and = 1'($urandom_range(1));
      run(400, cyc);
      check_run($sformatf("rand%0d", r), mode_and, 4);
    end
    rand_rdy = 1'b0;
    mode_and = 1'b0;

    // 255 vectors; a second start mid-run must not restart it.
    @(negedge CLK); start2 = 1'b1;
    @(posedge CLK);
    @(negedge CLK); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 1000) begin
      if (cyc == 20) begin
        start2 = 1'b1;
      end else begin
        start2 = 1'b0;
      end
      @(posedge CLK); @(negedge CLK); cyc++;
      if (cyc == 21) check("big_busy_after_restart", int'(busy2), 1);
    end
    start2 = 1'b0;
    check("big_cycles", cyc, 510);
    check("big_done", int'(done2), 1);
    check("big_pass", int'(pass_count2), 255);
    check("big_fail", int'(fail_count2), 0);
    check("big_timeout", int'(timeout2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
